// File: rtl/ascon_pkg.sv
// Shared constants and FSM encoding for the Ascon permutation arbiter.
package ascon_pkg;

    localparam int unsigned STATE_W        = 320;
    localparam int unsigned ROUNDS_MAX     = 12;
    localparam int unsigned PA_ROUNDS      = 12;
    localparam int unsigned PB_ROUNDS_HASH = 12;

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StRun,
        StResp
    } arb_state_e;

    function automatic logic rounds_legal(input int unsigned rounds);
        return (rounds >= 1) && (rounds <= ROUNDS_MAX);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping modulo N.
module rr_pick #(
    parameter int unsigned N    = 3,
    parameter int unsigned IDXW = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [IDXW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [IDXW-1:0] idx_o,
    output logic            any_o
);

    always_comb begin
        logic [IDXW-1:0] cidx;
        cidx  = '0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            cidx = IDXW'((32'(ptr_i) + k) % N);
            if (!any_o && req_i[cidx]) begin
                any_o       = 1'b1;
                gnt_o[cidx] = 1'b1;
                idx_o       = cidx;
            end
        end
    end

endmodule

// File: rtl/perm_arbiter.sv
// Shares one Ascon permutation core between N requesters with round-robin grant,
// round-count validation and a watchdog on the core's done pulse.
module perm_arbiter
    import ascon_pkg::*;
#(
    parameter int unsigned N   = 3,
    parameter int unsigned RW  = 5,
    parameter int unsigned TMO = 31
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    output logic [N-1:0]         req_ready,
    input  logic [N*STATE_W-1:0] req_state,
    input  logic [N*RW-1:0]      req_rounds,
    output logic [N-1:0]         rsp_valid,
    output logic                 rsp_err,
    output logic [STATE_W-1:0]   rsp_state,
    output logic                 p_start,
    output logic [STATE_W-1:0]   p_state,
    output logic [RW-1:0]        p_rounds,
    input  logic                 p_done,
    input  logic [STATE_W-1:0]   p_out,
    output logic                 busy
);

    localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned WDW  = $clog2(TMO + 1);

    arb_state_e         state_q;
    logic [IDXW-1:0]    rr_ptr_q;
    logic [IDXW-1:0]    idx_q;
    logic [STATE_W-1:0] st_q;
    logic [RW-1:0]      rounds_q;
    logic [WDW-1:0]     wdog_q;
    logic               p_start_q;
    logic [N-1:0]       rsp_valid_q;
    logic               rsp_err_q;
    logic [STATE_W-1:0] rsp_state_q;

    logic [N-1:0]       gnt;
    logic [IDXW-1:0]    pick_idx;
    logic               pick_any;
    logic [STATE_W-1:0] sel_state;
    logic [RW-1:0]      sel_rounds;
    logic [N-1:0]       idx_onehot;

    rr_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_rr_pick (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign sel_state  = req_state[32'(pick_idx) * STATE_W +: STATE_W];
    assign sel_rounds = req_rounds[32'(pick_idx) * RW +: RW];
    assign idx_onehot = N'(1) << idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            idx_q       <= '0;
            st_q        <= '0;
            rounds_q    <= '0;
            wdog_q      <= '0;
            p_start_q   <= 1'b0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_state_q <= '0;
        end else begin
            // Response fields live for exactly the one RESP cycle.
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_state_q <= '0;
            unique case (state_q)
                StIdle: begin
                    if (pick_any) begin
                        st_q     <= sel_state;
                        rounds_q <= sel_rounds;
                        idx_q    <= pick_idx;
                        state_q  <= StCheck;
                    end
                end
                StCheck: begin
                    if (rounds_legal(32'(rounds_q))) begin
                        wdog_q    <= '0;
                        p_start_q <= 1'b1;
                        state_q   <= StRun;
                    end else begin
                        rsp_valid_q <= idx_onehot;
                        rsp_err_q   <= 1'b1;
                        rsp_state_q <= st_q;
                        state_q     <= StResp;
                    end
                end
                StRun: begin
                    // Done takes priority over a timeout landing in the same cycle.
                    if (p_done) begin
                        rsp_valid_q <= idx_onehot;
                        rsp_state_q <= p_out;
                        p_start_q   <= 1'b0;
                        wdog_q      <= '0;
                        state_q     <= StResp;
                    end else if (wdog_q == WDW'(TMO - 1)) begin
                        rsp_valid_q <= idx_onehot;
                        rsp_err_q   <= 1'b1;
                        rsp_state_q <= st_q;
                        p_start_q   <= 1'b0;
                        wdog_q      <= '0;
                        state_q     <= StResp;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                StResp: begin
                    rr_ptr_q <= (idx_q == IDXW'(N - 1)) ? '0 : idx_q + 1'b1;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready = (state_q == StIdle && !rst) ? gnt : '0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_state = rsp_state_q;
    assign p_start   = p_start_q;
    assign p_state   = p_start_q ? st_q : '0;
    assign p_rounds  = p_start_q ? rounds_q : '0;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_perm_arbiter.sv
// Directed bench for perm_arbiter with a mock permutation core of programmable latency.
module tb_perm_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned RW = 5;
    localparam int unsigned SW = 320;
    localparam logic [SW-1:0] MASK    = {64'hDEADBEEF0BADF00D, 256'h0};
    localparam logic [SW-1:0] TIE_OUT = (320'h55 << 160) ^ MASK;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*SW-1:0] req_state;
    logic [N*RW-1:0] req_rounds;
    logic [N-1:0]    rsp_valid;
    logic            rsp_err;
    logic [SW-1:0]   rsp_state;
    logic            p_start;
    logic [SW-1:0]   p_state;
    logic [RW-1:0]   p_rounds;
    logic            p_done;
    logic [SW-1:0]   p_out;
    logic            busy;

    int n_checks;
    int n_fail;

    // Mock core: done on the core_lat-th cycle of p_start; output is a half-swap xor MASK.
    int   core_lat;
    bit   core_hang;
    logic stray_done;
    int   run_cnt;

    always @(posedge clk) run_cnt <= p_start ? run_cnt + 1 : 0;
    assign p_done = stray_done | (p_start && !core_hang && run_cnt == core_lat - 1);
    assign p_out  = {p_state[159:0], p_state[319:160]} ^ MASK;

    perm_arbiter #(
        .N   (N),
        .RW  (RW),
        .TMO (31)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_state  (req_state),
        .req_rounds (req_rounds),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_state  (rsp_state),
        .p_start    (p_start),
        .p_state    (p_state),
        .p_rounds   (p_rounds),
        .p_done     (p_done),
        .p_out      (p_out),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request and measures it up to its response; does not judge anything.
    task automatic transact(input int i, input logic [SW-1:0] st, input logic [RW-1:0] rn,
                            output logic [N-1:0] rdy, output int lat, output int starts,
                            output logic [N-1:0] rv, output logic er, output logic [SW-1:0] rs,
                            output logic ps_rsp, output bit p_ok);
        @(negedge clk);
        req_valid                = N'(1) << i;
        req_state                = '0;
        req_state[i*SW +: SW]    = st;
        req_rounds               = '0;
        req_rounds[i*RW +: RW]   = rn;
        #1 rdy = req_ready;
        lat    = -1;
        starts = 0;
        rv     = '0;
        er     = 1'b0;
        rs     = '0;
        ps_rsp = 1'b1;
        p_ok   = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = '0;
            if (p_start) begin
                starts++;
                if (p_state !== st || p_rounds !== rn) p_ok = 1'b0;
            end
            if (rsp_valid !== '0) begin
                lat    = c;
                rv     = rsp_valid;
                er     = rsp_err;
                rs     = rsp_state;
                ps_rsp = p_start;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (req_ready !== 3'b000) begin n_fail++;
            $display("FAIL reset_ready: got %b want 000", req_ready); end
        n_checks++; if (rsp_valid !== 3'b000 || rsp_err !== 1'b0 || rsp_state !== '0) begin n_fail++;
            $display("FAIL reset_rsp: got v=%b e=%b s=%h want zeros", rsp_valid, rsp_err, rsp_state); end
        n_checks++; if (p_start !== 1'b0 || p_state !== '0 || p_rounds !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_core_if: got start=%b rounds=%0d busy=%b want 0", p_start, p_rounds, busy); end
        @(negedge clk);
        req_valid = '0;
        rst = 1'b0;
    endtask

    task automatic test_fairness();
        logic [N-1:0] grants [6];
        int  ng;
        bit  pending;
        core_lat = 1;
        ng = 0;
        pending = 0;
        @(negedge clk);
        for (int j = 0; j < N; j++) begin
            req_state[j*SW +: SW]  = SW'(j + 1);
            req_rounds[j*RW +: RW] = RW'(1);
        end
        req_valid = 3'b111;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (req_ready !== '0) begin
                n_checks++; if (pending) begin n_fail++;
                    $display("FAIL fair_overlap: grant %b while txn %0d pending", req_ready, ng); end
                n_checks++; if (req_ready !== (N'(1) << (ng % N))) begin n_fail++;
                    $display("FAIL fair_order[%0d]: got %b want %b", ng, req_ready, N'(1) << (ng % N)); end
                grants[ng] = req_ready;
                ng++;
                pending = 1;
            end
            if (rsp_valid !== '0) begin
                n_checks++; if (rsp_valid !== grants[ng-1] || rsp_err !== 1'b0) begin n_fail++;
                    $display("FAIL fair_rsp[%0d]: got v=%b e=%b want v=%b e=0",
                             ng - 1, rsp_valid, rsp_err, grants[ng-1]); end
                n_checks++;
                if (rsp_state !== ((SW'((ng - 1) % N + 1) << 160) ^ MASK)) begin n_fail++;
                    $display("FAIL fair_state[%0d]: got %h", ng - 1, rsp_state); end
                pending = 0;
                if (ng == 6) begin
                    req_valid = '0;
                    break;
                end
            end
            @(negedge clk);
        end
        req_valid = '0;
        n_checks++; if (ng != 6 || pending) begin n_fail++;
            $display("FAIL fair_count: got %0d grants pending=%0d want 6 pending=0", ng, pending); end
    endtask

    task automatic test_single();
        logic [N-1:0] rdy, rv; int lat, starts; logic er, ps; logic [SW-1:0] rs; bit pok;
        core_lat = 12;
        transact(0, '0, RW'(12), rdy, lat, starts, rv, er, rs, ps, pok);
        n_checks++; if (rdy !== 3'b001) begin n_fail++;
            $display("FAIL single_ready: got %b want 001", rdy); end
        n_checks++; if (lat != 14) begin n_fail++;
            $display("FAIL single_latency: got %0d want 14", lat); end
        n_checks++; if (starts != 12 || !pok) begin n_fail++;
            $display("FAIL single_start: got %0d cycles stable=%0d want 12 stable=1", starts, pok); end
        n_checks++; if (rv !== 3'b001 || er !== 1'b0 || rs !== MASK) begin n_fail++;
            $display("FAIL single_rsp: got v=%b e=%b s=%h want v=001 e=0 s=%h", rv, er, rs, MASK); end
    endtask

    task automatic test_illegal();
        logic [N-1:0] rdy, rv; int lat, starts; logic er, ps; logic [SW-1:0] rs; bit pok;
        logic [RW-1:0] bad [2];
        bad[0] = RW'(0);
        bad[1] = RW'(13);
        core_lat = 2;
        for (int t = 0; t < 2; t++) begin
            transact(t + 1, 320'h1234, bad[t], rdy, lat, starts, rv, er, rs, ps, pok);
            n_checks++; if (lat != 2 || starts != 0) begin n_fail++;
                $display("FAIL illegal_timing[%0d]: got lat=%0d starts=%0d want 2/0", bad[t], lat, starts); end
            n_checks++; if (rv !== (N'(1) << (t + 1)) || er !== 1'b1 || rs !== 320'h1234) begin n_fail++;
                $display("FAIL illegal_rsp[%0d]: got v=%b e=%b s=%h want e=1 s=1234", bad[t], rv, er, rs); end
        end
    endtask

    task automatic test_timeout();
        logic [N-1:0] rdy, rv; int lat, starts; logic er, ps; logic [SW-1:0] rs; bit pok;
        core_hang = 1;
        transact(0, 320'hABCD, RW'(12), rdy, lat, starts, rv, er, rs, ps, pok);
        core_hang = 0;
        n_checks++; if (lat != 33 || starts != 31) begin n_fail++;
            $display("FAIL timeout_timing: got lat=%0d starts=%0d want 33/31", lat, starts); end
        n_checks++; if (rv !== 3'b001 || er !== 1'b1 || rs !== 320'hABCD || ps !== 1'b0) begin n_fail++;
            $display("FAIL timeout_rsp: got v=%b e=%b s=%h start=%b", rv, er, rs, ps); end
    endtask

    task automatic test_tie();
        logic [N-1:0] rdy, rv; int lat, starts; logic er, ps; logic [SW-1:0] rs; bit pok;
        core_lat = 31;
        transact(1, 320'h55, RW'(12), rdy, lat, starts, rv, er, rs, ps, pok);
        n_checks++; if (lat != 33 || rv !== 3'b010) begin n_fail++;
            $display("FAIL tie_timing: got lat=%0d v=%b want 33/010", lat, rv); end
        n_checks++; if (er !== 1'b0 || rs !== TIE_OUT) begin n_fail++;
            $display("FAIL tie_rsp: got e=%b s=%h want e=0 s=%h", er, rs, TIE_OUT); end
    endtask

    task automatic test_stray_done();
        @(negedge clk);
        stray_done = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_checks++; if (busy !== 1'b0 || rsp_valid !== '0 || p_start !== 1'b0) begin n_fail++;
                $display("FAIL stray_done: got busy=%b v=%b start=%b want 0", busy, rsp_valid, p_start); end
        end
        stray_done = 1'b0;
    endtask

    task automatic test_reset_in_run();
        int lat;
        bit dropped_rsp;
        core_lat = 12;
        @(negedge clk);
        req_valid = 3'b010;
        req_state[SW +: SW]  = 320'h99;
        req_rounds[RW +: RW] = RW'(12);
        repeat (6) @(negedge clk);
        req_valid = '0;
        n_checks++; if (p_start !== 1'b1) begin n_fail++;
            $display("FAIL rst_run_pre: got start=%b want 1", p_start); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (req_ready !== '0 || rsp_valid !== '0 || rsp_err !== 1'b0 || rsp_state !== '0
                        || p_start !== 1'b0 || p_state !== '0 || p_rounds !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_run_outputs: got rdy=%b v=%b start=%b busy=%b want 0",
                     req_ready, rsp_valid, p_start, busy); end
        @(negedge clk);
        rst = 1'b0;
        req_valid = 3'b100;
        req_state[2*SW +: SW]    = 320'h77;
        req_rounds[2*RW +: RW]   = RW'(12);
        #1;
        n_checks++; if (req_ready !== 3'b100) begin n_fail++;
            $display("FAIL rst_run_regrant: got %b want 100", req_ready); end
        lat = -1;
        dropped_rsp = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = '0;
            if (rsp_valid === 3'b010) dropped_rsp = 1;
            if (rsp_valid === 3'b100 && lat < 0) lat = c;
        end
        n_checks++; if (dropped_rsp) begin n_fail++;
            $display("FAIL rst_run_dropped: got response for reset request, want none"); end
        n_checks++; if (lat != 14) begin n_fail++;
            $display("FAIL rst_run_next: got latency %0d want 14", lat); end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        req_valid  = '0;
        req_state  = '0;
        req_rounds = '0;
        core_lat   = 12;
        core_hang  = 0;
        stray_done = 1'b0;
        test_reset();
        test_fairness();
        test_single();
        test_illegal();
        test_timeout();
        test_tie();
        test_stray_done();
        test_reset_in_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
